nw_chunk_loader: RTL and testbench
==================================

# nw_chunk_loader

Upstream feeder for the Needleman-Wunsch `Grid` chunk. It accepts one character pair per cycle over a valid/ready handshake and packs LENGTH pairs into the `s1`/`s2` chunk strings. It drives the initial boundary scores, pulses the grid clear, holds the chunk stable while the grid computes, and captures the bottom-right score when the grid reports valid.

## Interface
- `LENGTH`, 10: characters per chunk, one per grid row/column.
- `CWIDTH`, 2: bits per character.
- `SWIDTH`, 16: bits per signed score.
- `INDEL`, -1: signed gap penalty used for the boundary scores.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  a character pair is presented.
- `in_c1`  in  CWIDTH  character of string 1.
- `in_c2`  in  CWIDTH  character of string 2.
- `in_ready`  out  1  the loader accepts a pair this cycle.
- `s1`  out  LENGTH*CWIDTH  packed string 1 chunk to the grid.
- `s2`  out  LENGTH*CWIDTH  packed string 2 chunk to the grid.
- `top_scores`  out  (LENGTH+1)*SWIDTH  top boundary plus corner for the grid.
- `left_scores`  out  LENGTH*SWIDTH  left boundary for the grid.
- `grid_reset`  out  1  clear to the grid's valid flags.
- `chunk_valid`  out  1  s1/s2/boundaries are stable and the grid is computing.
- `grid_done`  in  1  grid valid output.
- `grid_corner`  in  SWIDTH  grid bottom-right score.
- `score`  out  SWIDTH  captured final score (signed).
- `score_valid`  out  1  one-cycle pulse when `score` updates.
- `run_cycles`  out  16  cycles spent in the last RUN, saturating at 16'hFFFF.

## Operation
- States:
  - LOAD: reset/default state. `in_ready`=1.
  - CLEAR: lasts exactly 1 cycle.
  - RUN.
- Only LOAD accepts input. A pair is accepted on a cycle with `in_valid && in_ready`.
  - The k-th accepted pair (k=0..LENGTH-1) writes `s1[k*CWIDTH +: CWIDTH]` and `s2[k*CWIDTH +: CWIDTH]`.
  - The write index counts 0..LENGTH-1.
  - Accepting pair LENGTH-1 moves the block to CLEAR and resets the index to 0.
- In CLEAR: `grid_reset`=1, and `run_cycles` internal counter clears to 0. The next state is RUN.
- In RUN:
  - `chunk_valid`=1 and `in_ready`=0. s1/s2/boundaries are frozen.
  - The counter increments every RUN cycle and saturates.
  - `grid_done` is sampled only in RUN and is ignored in all other states.
  - On the first RUN cycle with `grid_done`=1:
    - `score` <= `grid_corner`.
    - `score_valid` is 1 on the next cycle.
    - `run_cycles` <= counter+1, which includes the done cycle.
    - The next state is LOAD.
- Boundary scores are constant functions of the parameters, held in registers and loaded at reset:
  - `top_scores[i*SWIDTH +: SWIDTH]` = i*INDEL for i=0..LENGTH.
  - `left_scores[j*SWIDTH +: SWIDTH]` = (j+1)*INDEL for j=0..LENGTH-1.
  - Computed as a signed product truncated to SWIDTH.
- `grid_reset` = `reset` OR (state==CLEAR). It is combinational from the state register, so the grid is held clear throughout reset.
- Reset values:
  - state LOAD, index 0.
  - `s1`=`s2`=0.
  - `score`=0, `score_valid`=0, `run_cycles`=0, `chunk_valid`=0.
  - `in_ready`=0 while `reset`=1, then 1 in LOAD.
  - Boundary registers hold their constant values.
- Reset mid-operation, in any state: the cycle after reset is in LOAD with index 0. Partial chunks are discarded, and no `score_valid` is pulsed.

## Timing
- `in_ready` and `chunk_valid` are decoded from the state register only, with no combinational path from `in_valid` or `grid_done`.
- Load phase: the minimum is LENGTH cycles with `in_valid` held high. Gaps with `in_valid`=0 stall the index with no penalty.
- Sequence from the LOAD accept of pair LENGTH-1 (cycle T):
  - T+1: CLEAR (`grid_reset`=1).
  - T+2: first RUN cycle.
- With `grid_done` first high at RUN cycle R:
  - `score_valid`=1 and the new `score` are visible at R+1.
  - State is LOAD (`in_ready`=1) at R+1.
  - The next pair can be accepted at R+1.
- `score` holds its value until the next capture. `score_valid` is exactly one cycle wide.
- If `in_valid` is high during CLEAR/RUN, nothing is accepted and the characters are not corrupted.

## Test plan
- Reset then idle:
  - `s1`=`s2`=0, `score`=0, `run_cycles`=0.
  - `top_scores` = {-10,…,-1,0}, `left_scores` = {-10,…,-1} (LENGTH=10, INDEL=-1).
  - `grid_reset`=1 during reset.
- Load ACGTACGTAC / AAAAAAAAAA (2-bit codes 0..3) back-to-back:
  - `s1`=20'h4E4E4 packing-order checked per slot, `s2`=0.
  - `grid_reset` pulses exactly at T+1.
  - `chunk_valid` rises at T+2.
- Load with `in_valid` toggling every other cycle: the same `s1`/`s2` result is reached after 20 cycles, and the CLEAR timing is unchanged.
- In RUN, drive `grid_done`=0 for 14 cycles, then 1 with `grid_corner`=-3:
  - `score`=16'hFFFD, `score_valid` pulses once, `run_cycles`=15.
  - `in_ready`=1 the next cycle.
- `grid_done`=1 held during LOAD and CLEAR: it is ignored (no `score_valid`). Capture happens on the first RUN cycle with `run_cycles`=1.
- Assert `reset` after 6 pairs are loaded, then load 10 new pairs: `s1`/`s2` reflect only the new pairs, and no spurious `score_valid` occurs.

Source files
------------

// File: rtl/nw_chunk_loader.sv
// nw_chunk_loader
// Upstream feeder for the Needleman-Wunsch Grid chunk. Collects LENGTH
// character pairs over a valid/ready handshake, then clears the grid for one
// cycle and holds the chunk stable while the grid computes. Once the grid
// reports done, the bottom-right score and the run length are captured.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   in_valid/in_ready   character pair handshake (accepted only while loading)
//   in_c1, in_c2        characters of string 1 / string 2
//   s1, s2              packed chunk strings, pair k in slot k
//   top_scores          boundary row plus corner, slot i = i*INDEL
//   left_scores         boundary column, slot j = (j+1)*INDEL
//   grid_reset          clear for the grid's valid flags
//   chunk_valid         chunk and boundaries stable, grid computing
//   grid_done           grid valid output
//   grid_corner         grid bottom-right score
//   score, score_valid  captured score and its one-cycle update pulse
//   run_cycles          length of the last run, saturating
module nw_chunk_loader #(
    parameter int LENGTH = 10,
    parameter int CWIDTH = 2,
    parameter int SWIDTH = 16,
    parameter int INDEL  = -1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic [CWIDTH-1:0]            in_c1,
    input  logic [CWIDTH-1:0]            in_c2,
    output logic                         in_ready,
    output logic [LENGTH*CWIDTH-1:0]     s1,
    output logic [LENGTH*CWIDTH-1:0]     s2,
    output logic [(LENGTH+1)*SWIDTH-1:0] top_scores,
    output logic [LENGTH*SWIDTH-1:0]     left_scores,
    output logic                         grid_reset,
    output logic                         chunk_valid,
    input  logic                         grid_done,
    input  logic [SWIDTH-1:0]            grid_corner,
    output logic [SWIDTH-1:0]            score,
    output logic                         score_valid,
    output logic [15:0]                  run_cycles
);

    localparam int IW = (LENGTH > 1) ? $clog2(LENGTH) : 1;

    localparam logic [1:0] ST_LOAD  = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

    function automatic logic [(LENGTH+1)*SWIDTH-1:0] top_init();
        logic [(LENGTH+1)*SWIDTH-1:0] v;
        v = '0;
        for (int i = 0; i <= LENGTH; i++) begin
            v[i*SWIDTH +: SWIDTH] = SWIDTH'(i * INDEL);
        end
        return v;
    endfunction

    function automatic logic [LENGTH*SWIDTH-1:0] left_init();
        logic [LENGTH*SWIDTH-1:0] v;
        v = '0;
        for (int j = 0; j < LENGTH; j++) begin
            v[j*SWIDTH +: SWIDTH] = SWIDTH'((j + 1) * INDEL);
        end
        return v;
    endfunction

    localparam logic [(LENGTH+1)*SWIDTH-1:0] TOP_INIT  = top_init();
    localparam logic [LENGTH*SWIDTH-1:0]     LEFT_INIT = left_init();

    logic [1:0]                   state_q, state_d;
    logic [IW-1:0]                idx_q, idx_d;
    logic [LENGTH*CWIDTH-1:0]     s1_q, s1_d;
    logic [LENGTH*CWIDTH-1:0]     s2_q, s2_d;
    logic [15:0]                  cnt_q, cnt_d;
    logic [15:0]                  cnt_inc;
    logic [SWIDTH-1:0]            score_q, score_d;
    logic                         score_valid_q, score_valid_d;
    logic [15:0]                  run_cycles_q, run_cycles_d;
    logic [(LENGTH+1)*SWIDTH-1:0] top_q;
    logic [LENGTH*SWIDTH-1:0]     left_q;

    // Handshake and grid controls depend only on the state register and
    // reset, never on in_valid or grid_done.
    assign in_ready    = (state_q == ST_LOAD) && !reset;
    assign chunk_valid = (state_q == ST_RUN) && !reset;
    assign grid_reset  = reset || (state_q == ST_CLEAR);

    assign s1          = s1_q;
    assign s2          = s2_q;
    assign top_scores  = top_q;
    assign left_scores = left_q;
    assign score       = score_q;
    assign score_valid = score_valid_q;
    assign run_cycles  = run_cycles_q;

    assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        s1_d          = s1_q;
        s2_d          = s2_q;
        cnt_d         = cnt_q;
        score_d       = score_q;
        score_valid_d = 1'b0;
        run_cycles_d  = run_cycles_q;
        case (state_q)
            ST_LOAD: begin
                if (in_valid) begin
                    s1_d[idx_q*CWIDTH +: CWIDTH] = in_c1;
                    s2_d[idx_q*CWIDTH +: CWIDTH] = in_c2;
                    if (idx_q == IW'(LENGTH - 1)) begin
                        idx_d   = '0;
                        state_d = ST_CLEAR;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_CLEAR: begin
                cnt_d   = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                cnt_d = cnt_inc;
                // The done cycle itself counts toward the reported run length.
                if (grid_done) begin
                    score_d       = grid_corner;
                    score_valid_d = 1'b1;
                    run_cycles_d  = cnt_inc;
                    state_d       = ST_LOAD;
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_LOAD;
            idx_q         <= '0;
            s1_q          <= '0;
            s2_q          <= '0;
            cnt_q         <= '0;
            score_q       <= '0;
            score_valid_q <= 1'b0;
            run_cycles_q  <= '0;
            top_q         <= TOP_INIT;
            left_q        <= LEFT_INIT;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            s1_q          <= s1_d;
            s2_q          <= s2_d;
            cnt_q         <= cnt_d;
            score_q       <= score_d;
            score_valid_q <= score_valid_d;
            run_cycles_q  <= run_cycles_d;
        end
    end

endmodule

// File: tb/tb_nw_chunk_loader.sv
// Testbench for nw_chunk_loader: directed scenarios with literal expectations
// plus a randomized phase, all outputs compared every cycle against a
// timestamp-based behavioural model.
module tb_nw_chunk_loader;

    localparam int LENGTH = 10;
    localparam int CWIDTH = 2;
    localparam int SWIDTH = 16;
    localparam int INDEL  = -1;

    logic                         clk;
    logic                         reset;
    logic                         in_valid;
    logic [CWIDTH-1:0]            in_c1;
    logic [CWIDTH-1:0]            in_c2;
    logic                         in_ready;
    logic [LENGTH*CWIDTH-1:0]     s1;
    logic [LENGTH*CWIDTH-1:0]     s2;
    logic [(LENGTH+1)*SWIDTH-1:0] top_scores;
    logic [LENGTH*SWIDTH-1:0]     left_scores;
    logic                         grid_reset;
    logic                         chunk_valid;
    logic                         grid_done;
    logic [SWIDTH-1:0]            grid_corner;
    logic [SWIDTH-1:0]            score;
    logic                         score_valid;
    logic [15:0]                  run_cycles;

    int checks = 0;
    int errors = 0;
    bit check_en = 0;

    nw_chunk_loader #(
        .LENGTH(LENGTH), .CWIDTH(CWIDTH), .SWIDTH(SWIDTH), .INDEL(INDEL)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_c1(in_c1),
        .in_c2(in_c2), .in_ready(in_ready), .s1(s1), .s2(s2),
        .top_scores(top_scores), .left_scores(left_scores),
        .grid_reset(grid_reset), .chunk_valid(chunk_valid),
        .grid_done(grid_done), .grid_corner(grid_corner), .score(score),
        .score_valid(score_valid), .run_cycles(run_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: accepted characters kept in arrays; the chunk phase is derived
    // from the cycle number at which the chunk was completed.
    int                cyc = 0;
    bit                busy = 0;
    int                t_full = 0;
    int                n = 0;
    logic [CWIDTH-1:0] m_c1 [LENGTH];
    logic [CWIDTH-1:0] m_c2 [LENGTH];
    logic [SWIDTH-1:0] m_score;
    logic              m_sv;
    logic [15:0]       m_rc;

    always @(posedge clk) begin
        if (reset) begin
            busy = 0;
            n = 0;
            for (int k = 0; k < LENGTH; k++) begin
                m_c1[k] = '0;
                m_c2[k] = '0;
            end
            m_score = '0;
            m_sv = 1'b0;
            m_rc = '0;
        end else begin
            m_sv = 1'b0;
            if (!busy) begin
                if (in_valid) begin
                    m_c1[n] = in_c1;
                    m_c2[n] = in_c2;
                    n++;
                    if (n == LENGTH) begin
                        n = 0;
                        busy = 1;
                        t_full = cyc;
                    end
                end
            end else if (cyc >= t_full + 2 && grid_done) begin
                m_score = grid_corner;
                m_sv = 1'b1;
                m_rc = ((cyc - t_full - 1) > 65535) ? 16'hFFFF : 16'(cyc - t_full - 1);
                busy = 0;
            end
        end
        cyc++;
    end

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            logic [LENGTH*CWIDTH-1:0]     e_s1, e_s2;
            logic [(LENGTH+1)*SWIDTH-1:0] e_top;
            logic [LENGTH*SWIDTH-1:0]     e_left;
            for (int k = 0; k < LENGTH; k++) begin
                e_s1[k*CWIDTH +: CWIDTH] = m_c1[k];
                e_s2[k*CWIDTH +: CWIDTH] = m_c2[k];
                e_left[k*SWIDTH +: SWIDTH] = SWIDTH'((k + 1) * INDEL);
            end
            for (int k = 0; k <= LENGTH; k++) begin
                e_top[k*SWIDTH +: SWIDTH] = SWIDTH'(k * INDEL);
            end
            checkOutput("in_ready", 256'(in_ready), 256'(!reset && !busy));
            checkOutput("chunk_valid", 256'(chunk_valid), 256'(!reset && busy && cyc >= t_full + 2));
            checkOutput("grid_reset", 256'(grid_reset), 256'(reset || (busy && cyc == t_full + 1)));
            checkOutput("s1", 256'(s1), 256'(e_s1));
            checkOutput("s2", 256'(s2), 256'(e_s2));
            checkOutput("score", 256'(score), 256'(m_score));
            checkOutput("score_valid", 256'(score_valid), 256'(m_sv));
            checkOutput("run_cycles", 256'(run_cycles), 256'(m_rc));
            checkOutput("top_scores", 256'(top_scores), 256'(e_top));
            checkOutput("left_scores", 256'(left_scores), 256'(e_left));
        end
    end

    // Drives one cycle of inputs shortly after the rising edge and returns at
    // the falling edge of that same cycle so its outputs can be inspected.
    task automatic applyStimulus(input logic rst, input logic v, input logic [CWIDTH-1:0] c1,
                                 input logic [CWIDTH-1:0] c2, input logic done,
                                 input logic [SWIDTH-1:0] corner);
        @(posedge clk);
        #1;
        reset       = rst;
        in_valid    = v;
        in_c1       = c1;
        in_c2       = c2;
        grid_done   = done;
        grid_corner = corner;
        @(negedge clk);
    endtask

    int acgt [LENGTH] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1};
    int tc   [LENGTH] = '{3, 1, 3, 1, 3, 1, 3, 1, 3, 1};

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        in_c1 = '0;
        in_c2 = '0;
        grid_done = 1'b0;
        grid_corner = '0;

        // Reset then idle
        applyStimulus(1, 0, 0, 0, 0, 0);
        check_en = 1;
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("rst_grid_reset", 256'(grid_reset), 256'(1'b1));
        checkOutput("rst_in_ready", 256'(in_ready), 256'(1'b0));
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("idle_s1", 256'(s1), 256'(0));
        checkOutput("idle_score", 256'(score), 256'(0));
        checkOutput("idle_run_cycles", 256'(run_cycles), 256'(0));
        checkOutput("idle_top", 256'(top_scores),
            256'({16'hFFF6, 16'hFFF7, 16'hFFF8, 16'hFFF9, 16'hFFFA, 16'hFFFB,
                  16'hFFFC, 16'hFFFD, 16'hFFFE, 16'hFFFF, 16'h0000}));
        checkOutput("idle_left", 256'(left_scores),
            256'({16'hFFF6, 16'hFFF7, 16'hFFF8, 16'hFFF9, 16'hFFFA, 16'hFFFB,
                  16'hFFFC, 16'hFFFD, 16'hFFFE, 16'hFFFF}));

        // Back-to-back load of ACGTACGTAC / AAAAAAAAAA
        for (int i = 0; i < LENGTH; i++) begin
            applyStimulus(0, 1, CWIDTH'(acgt[i]), 0, 0, 0);
        end
        applyStimulus(0, 1, 3, 3, 0, 0);
        checkOutput("b2b_clear_pulse", 256'(grid_reset), 256'(1'b1));
        checkOutput("b2b_s1", 256'(s1), 256'(20'h4E4E4));
        checkOutput("b2b_s2", 256'(s2), 256'(0));
        applyStimulus(0, 1, 3, 3, 0, 0);
        checkOutput("b2b_chunk_valid", 256'(chunk_valid), 256'(1'b1));
        checkOutput("b2b_clear_end", 256'(grid_reset), 256'(1'b0));
        for (int i = 0; i < 13; i++) begin
            applyStimulus(0, 1, 3, 3, 0, 0);
        end
        applyStimulus(0, 0, 0, 0, 1, 16'hFFFD);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("cap_score", 256'(score), 256'(16'hFFFD));
        checkOutput("cap_score_valid", 256'(score_valid), 256'(1'b1));
        checkOutput("cap_run_cycles", 256'(run_cycles), 256'(15));
        checkOutput("cap_in_ready", 256'(in_ready), 256'(1'b1));
        checkOutput("run_s1_frozen", 256'(s1), 256'(20'h4E4E4));
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("cap_pulse_end", 256'(score_valid), 256'(1'b0));

        // Toggled load with grid_done held high through LOAD and CLEAR
        applyStimulus(1, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 1, 0);
        checkOutput("rst_clears_s1", 256'(s1), 256'(0));
        for (int i = 0; i < 2 * LENGTH; i++) begin
            applyStimulus(0, 1'(i % 2), CWIDTH'(acgt[i / 2]), 0, 1, 16'h0007);
        end
        checkOutput("tog_no_early_sv", 256'(score_valid), 256'(1'b0));
        applyStimulus(0, 0, 0, 0, 1, 16'h0007);
        checkOutput("tog_clear_pulse", 256'(grid_reset), 256'(1'b1));
        checkOutput("tog_s1", 256'(s1), 256'(20'h4E4E4));
        checkOutput("tog_s2", 256'(s2), 256'(0));
        applyStimulus(0, 0, 0, 0, 1, 16'h0007);
        checkOutput("tog_chunk_valid", 256'(chunk_valid), 256'(1'b1));
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("tog_score", 256'(score), 256'(16'h0007));
        checkOutput("tog_run_cycles", 256'(run_cycles), 256'(1));
        checkOutput("tog_score_valid", 256'(score_valid), 256'(1'b1));

        // Randomized traffic, occasional resets
        for (int i = 0; i < 1500; i++) begin
            applyStimulus(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 3) != 0),
                          CWIDTH'($urandom), CWIDTH'($urandom),
                          1'($urandom_range(0, 5) == 0), SWIDTH'($urandom));
        end

        // Reset after a partial chunk of 6 pairs, then a fresh chunk
        applyStimulus(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 1, 3, 0, 0, 0);
        end
        applyStimulus(1, 1, 3, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("midrst_s1", 256'(s1), 256'(0));
        checkOutput("midrst_sv", 256'(score_valid), 256'(1'b0));
        checkOutput("midrst_ready", 256'(in_ready), 256'(1'b1));
        for (int i = 0; i < LENGTH; i++) begin
            applyStimulus(0, 1, 2, CWIDTH'(tc[i]), 0, 0);
        end
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("new_s1", 256'(s1), 256'(20'hAAAAA));
        checkOutput("new_s2", 256'(s2), 256'(20'h77777));
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 16'h0042);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("new_score", 256'(score), 256'(16'h0042));
        checkOutput("new_run_cycles", 256'(run_cycles), 256'(2));
        applyStimulus(0, 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
